// File: rtl/pulse_peak_detector.sv
// Threshold-crossing pulse detector: emits one record (peak, peak time, width, pile-up) per pulse.
// Optional area accumulator enabled by defining PEAK_DET_AREA_EN.
module pulse_peak_detector #(
  parameter int DATA_W      = 16,
  parameter int TS_W        = 16,
  parameter int WIDTH_W     = 8,
  parameter int HOLDOFF_CYC = 4,
  parameter int LOST_W      = 8,
  parameter int AREA_W      = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [DATA_W-1:0]  input_data,
  input  logic [DATA_W-1:0]  threshold,
  input  logic               event_ready,
  output logic               event_valid,
  output logic [DATA_W-1:0]  event_amp,
  output logic [TS_W-1:0]    event_time,
  output logic [WIDTH_W-1:0] event_width,
  output logic               event_pileup,
  output logic [AREA_W-1:0]  event_area,
  output logic [LOST_W-1:0]  lost_count,
  output logic [1:0]         dbg_state
);

  localparam int HCNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ABOVE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TS_W-1:0]     ts_q;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [TS_W-1:0]     tmax_q, tmax_d;
  logic [WIDTH_W-1:0]  width_q, width_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                pileup_q, pileup_d;

  logic                above;
  logic                start_trk, upd_trk, enter_hold, set_pile, push;

  logic                ev_valid_q, ev_valid_d;
  logic [DATA_W-1:0]   ev_amp_q, ev_amp_d;
  logic [TS_W-1:0]     ev_time_q, ev_time_d;
  logic [WIDTH_W-1:0]  ev_width_q, ev_width_d;
  logic                ev_pileup_q, ev_pileup_d;
  logic [LOST_W-1:0]   lost_q, lost_d;

  assign above     = $signed(input_data) > $signed(threshold);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable && above) state_d = S_ABOVE;
      S_ABOVE: begin
        if (!enable)     state_d = S_IDLE;
        else if (!above) state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (!enable)            state_d = S_IDLE;
        else if (hcnt_q == '0)  state_d = above ? S_ABOVE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push on the last holdoff cycle may restart the trackers from the same sample.
  always_comb begin
    start_trk  = 1'b0;
    upd_trk    = 1'b0;
    enter_hold = 1'b0;
    set_pile   = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE:  start_trk = enable && above;
      S_ABOVE: begin
        upd_trk    = enable && above;
        enter_hold = enable && !above;
      end
      S_HOLDOFF: begin
        set_pile  = enable && above;
        push      = enable && (hcnt_q == '0);
        start_trk = enable && above && (hcnt_q == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    max_d    = max_q;
    tmax_d   = tmax_q;
    width_d  = width_q;
    hcnt_d   = hcnt_q;
    pileup_d = pileup_q;
    if (start_trk) begin
      max_d   = input_data;
      tmax_d  = ts_q;
      width_d = WIDTH_W'(1);
    end else if (upd_trk) begin
      if (width_q != '1) width_d = width_q + WIDTH_W'(1);
      if ($signed(input_data) > $signed(max_q)) begin
        max_d  = input_data;
        tmax_d = ts_q;
      end
    end
    if (enter_hold) begin
      hcnt_d   = HCNT_W'(HOLDOFF_CYC - 1);
      pileup_d = 1'b0;
    end else if (state_q == S_HOLDOFF && hcnt_q != '0) begin
      hcnt_d = hcnt_q - HCNT_W'(1);
    end
    if (set_pile) pileup_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q    <= '0;
      tmax_q   <= '0;
      width_q  <= '0;
      hcnt_q   <= '0;
      pileup_q <= 1'b0;
    end else begin
      max_q    <= max_d;
      tmax_q   <= tmax_d;
      width_q  <= width_d;
      hcnt_q   <= hcnt_d;
      pileup_q <= pileup_d;
    end
  end

  // Handshake: a record transfers on any edge where event_valid && event_ready; while
  // valid is high and ready is low the record is held stable and new pushes are dropped.
  always_comb begin
    ev_valid_d  = ev_valid_q;
    ev_amp_d    = ev_amp_q;
    ev_time_d   = ev_time_q;
    ev_width_d  = ev_width_q;
    ev_pileup_d = ev_pileup_q;
    lost_d      = lost_q;
    if (push && (!ev_valid_q || event_ready)) begin
      ev_valid_d  = 1'b1;
      ev_amp_d    = max_q;
      ev_time_d   = tmax_q;
      ev_width_d  = width_q;
      ev_pileup_d = pileup_q | set_pile;
    end else if (push) begin
      if (lost_q != '1) lost_d = lost_q + LOST_W'(1);
    end else if (ev_valid_q && event_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_valid_q  <= 1'b0;
      ev_amp_q    <= '0;
      ev_time_q   <= '0;
      ev_width_q  <= '0;
      ev_pileup_q <= 1'b0;
      lost_q      <= '0;
    end else begin
      ev_valid_q  <= ev_valid_d;
      ev_amp_q    <= ev_amp_d;
      ev_time_q   <= ev_time_d;
      ev_width_q  <= ev_width_d;
      ev_pileup_q <= ev_pileup_d;
      lost_q      <= lost_d;
    end
  end

  assign event_valid  = ev_valid_q;
  assign event_amp    = ev_amp_q;
  assign event_time   = ev_time_q;
  assign event_width  = ev_width_q;
  assign event_pileup = ev_pileup_q;
  assign lost_count   = lost_q;

`ifdef PEAK_DET_AREA_EN
  logic [AREA_W-1:0] sample_ext;
  logic [AREA_W-1:0] area_q, area_d;
  logic [AREA_W-1:0] ev_area_q, ev_area_d;

  assign sample_ext = AREA_W'($signed(input_data));

  always_comb begin
    area_d    = area_q;
    ev_area_d = ev_area_q;
    if (start_trk)    area_d = sample_ext;
    else if (upd_trk) area_d = area_q + sample_ext;
    if (push && (!ev_valid_q || event_ready)) ev_area_d = area_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      area_q    <= '0;
      ev_area_q <= '0;
    end else begin
      area_q    <= area_d;
      ev_area_q <= ev_area_d;
    end
  end

  assign event_area = ev_area_q;
`else
  assign event_area = '0;
`endif

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed table-driven bench for pulse_peak_detector (DATA_W=16, HOLDOFF_CYC=4, threshold=100).
module tb_pulse_peak_detector;

`ifdef PEAK_DET_AREA_EN
  localparam bit AREA_ON = 1'b1;
`else
  localparam bit AREA_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] input_data;
  logic [15:0] threshold;
  logic        event_ready;
  logic        event_valid;
  logic [15:0] event_amp;
  logic [15:0] event_time;
  logic [7:0]  event_width;
  logic        event_pileup;
  logic [23:0] event_area;
  logic [7:0]  lost_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_ts    = 0;

  typedef struct {
    logic [15:0] data;
    logic        exp_valid;
    logic [15:0] exp_amp;
    logic [15:0] exp_time;
    logic [7:0]  exp_width;
    logic        exp_pileup;
    logic [23:0] exp_area;
  } vec_t;

  vec_t vq[$];

  pulse_peak_detector dut (
    .clk(clk), .reset(reset), .enable(enable), .input_data(input_data),
    .threshold(threshold), .event_ready(event_ready), .event_valid(event_valid),
    .event_amp(event_amp), .event_time(event_time), .event_width(event_width),
    .event_pileup(event_pileup), .event_area(event_area), .lost_count(lost_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [15:0] d, input logic rdy);
    enable      = en;
    input_data  = d;
    event_ready = rdy;
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic add_vec(input logic [15:0] d, input logic v, input logic [15:0] amp,
                         input logic [15:0] t, input logic [7:0] w, input logic p,
                         input logic [23:0] area);
    vec_t e;
    e.data = d; e.exp_valid = v; e.exp_amp = amp; e.exp_time = t;
    e.exp_width = w; e.exp_pileup = p; e.exp_area = area;
    vq.push_back(e);
  endtask

  task automatic check_event(input string tag, input logic [15:0] amp, input logic [15:0] t,
                             input logic [7:0] w, input logic p, input logic [23:0] area);
    check({tag, " valid"},  event_valid, 1);
    check({tag, " amp"},    event_amp, amp);
    check({tag, " time"},   event_time, t);
    check({tag, " width"},  event_width, w);
    check({tag, " pileup"}, event_pileup, p);
    check({tag, " area"},   event_area, AREA_ON ? area : 24'd0);
  endtask

  initial begin
    int t_a, t_b, t_c;
    reset = 1'b0; enable = 1'b0; input_data = '0; threshold = 16'd100; event_ready = 1'b1;
    #2;
    check("rst valid", event_valid, 0);
    check("rst amp", event_amp, 0);
    check("rst time", event_time, 0);
    check("rst width", event_width, 0);
    check("rst lost", lost_count, 0);
    check("rst state", dbg_state, 0);
    #6;
    reset = 1'b1;
    tb_ts = 0;

    // Basic pulse, equal peaks, pile-up inside holdoff; ts of step k is k.
    add_vec(0, 0, 0, 0, 0, 0, 0);     add_vec(50, 0, 0, 0, 0, 0, 0);
    add_vec(120, 0, 0, 0, 0, 0, 0);   add_vec(200, 0, 0, 0, 0, 0, 0);
    add_vec(150, 0, 0, 0, 0, 0, 0);   add_vec(80, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);     add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);     add_vec(0, 1, 200, 3, 3, 0, 470);
    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(120, 0, 0, 0, 0, 0, 0);   add_vec(200, 0, 0, 0, 0, 0, 0);
    add_vec(200, 0, 0, 0, 0, 0, 0);   add_vec(110, 0, 0, 0, 0, 0, 0);
    add_vec(90, 0, 0, 0, 0, 0, 0);    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0);     add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 200, 12, 4, 0, 630); add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(150, 0, 0, 0, 0, 0, 0);   add_vec(300, 0, 0, 0, 0, 0, 0);
    add_vec(50, 0, 0, 0, 0, 0, 0);    add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(130, 0, 0, 0, 0, 0, 0);   add_vec(0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 300, 22, 2, 1, 450); add_vec(0, 0, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      step(1'b1, vq[i].data, 1'b1);
      check($sformatf("vec%0d valid", i), event_valid, vq[i].exp_valid);
      check($sformatf("vec%0d lost", i), lost_count, 0);
      if (vq[i].exp_valid)
        check_event($sformatf("vec%0d", i), vq[i].exp_amp, vq[i].exp_time,
                    vq[i].exp_width, vq[i].exp_pileup, vq[i].exp_area);
    end

    // Backpressure: second event dropped, first held.
    t_a = tb_ts;
    step(1'b1, 16'd200, 1'b0);
    repeat (4) step(1'b1, 16'd0, 1'b0);
    check("bp latency", event_valid, 0);
    step(1'b1, 16'd0, 1'b0);
    check_event("bp first", 200, 16'(t_a), 1, 0, 200);
    step(1'b1, 16'd400, 1'b0);
    repeat (5) step(1'b1, 16'd0, 1'b0);
    check_event("bp held", 200, 16'(t_a), 1, 0, 200);
    check("bp lost", lost_count, 1);
    step(1'b1, 16'd0, 1'b1);
    check("bp consumed", event_valid, 0);

    // Enable dropped during holdoff discards the pulse.
    step(1'b1, 16'd200, 1'b1);
    step(1'b1, 16'd0, 1'b1);
    step(1'b1, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    check("en idle state", dbg_state, 0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 16'd0, 1'b1);
      check($sformatf("en discard %0d", k), event_valid, 0);
    end
    check("en lost", lost_count, 1);
    t_b = tb_ts;
    step(1'b1, 16'd250, 1'b1);
    repeat (4) step(1'b1, 16'd0, 1'b1);
    check("en next latency", event_valid, 0);
    step(1'b1, 16'd0, 1'b1);
    check_event("en next", 250, 16'(t_b), 1, 0, 250);
    check("en next lost", lost_count, 1);
    step(1'b1, 16'd0, 1'b1);
    check("en next consumed", event_valid, 0);

    // Long pulse: width saturates at 255.
    t_c = tb_ts;
    repeat (300) step(1'b1, 16'd200, 1'b1);
    repeat (4) step(1'b1, 16'd0, 1'b1);
    check("sat latency", event_valid, 0);
    step(1'b1, 16'd0, 1'b1);
    check_event("sat", 200, 16'(t_c), 255, 0, 60000);

    // Reset mid-pulse while an event is held.
    step(1'b1, 16'd150, 1'b0);
    step(1'b1, 16'd300, 1'b0);
    check("pre-rst valid", event_valid, 1);
    check("pre-rst state", dbg_state, 1);
    #2 reset = 1'b0;
    #1;
    check("arst valid", event_valid, 0);
    check("arst amp", event_amp, 0);
    check("arst time", event_time, 0);
    check("arst width", event_width, 0);
    check("arst pileup", event_pileup, 0);
    check("arst area", event_area, 0);
    check("arst lost", lost_count, 0);
    check("arst state", dbg_state, 0);
    input_data = 16'd0;
    #3 reset = 1'b1;
    tb_ts = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 16'd0, 1'b1);
      check($sformatf("post-rst %0d", k), event_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
